// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

    // Parity mode; encoding matches the config register field.
    typedef enum logic [1:0] {
        ParNone = 2'b00,
        ParEven = 2'b01,
        ParOdd  = 2'b10
    } par_mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } tx_state_e;

    localparam logic [3:0]  UART_ADDR_PARITY  = 4'h5;
    localparam logic [3:0]  UART_ADDR_STOP    = 4'h6;
    localparam int unsigned UART_CLKS_PER_BIT = 16;

    // Config field 2'b11 is an alias for "no parity".
    function automatic par_mode_e decode_parity(input logic [1:0] v);
        case (v)
            2'b01:   return ParEven;
            2'b10:   return ParOdd;
            default: return ParNone;
        endcase
    endfunction

    function automatic logic parity_bit(input logic [7:0] d, input par_mode_e m);
        return (m == ParOdd) ? ~(^d) : ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes queued for transmission.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));
    assign do_pop  = pop_i && !empty_o;
    // A push while full is allowed when a pop frees the slot in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q];

    // Pointer and occupancy next state.
    always_comb begin
        wr_d  = do_push ? next_ptr(wr_q) : wr_q;
        rd_d  = do_pop ? next_ptr(rd_q) : rd_q;
        cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_FIFO_EN to add a 4-entry byte FIFO for back-to-back frames.
// Note: rst_n is active-high and synchronous despite its name.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d_valid,
    input  logic [7:0] d_data,
    output logic       d_ready,
    input  logic       c_valid,
    input  logic [3:0] c_addr,
    input  logic [7:0] c_data,
    output logic       c_ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned     BaudW    = 12;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    par_mode_e        cfg_par_q, cfg_par_d, frm_par_q, frm_par_d;
    logic             cfg_stop_q, cfg_stop_d, frm_stop_q, frm_stop_d;
    logic             tx_q, tx_d;
    logic             cfg_we, bit_done, last_stop;
    logic             idle_take, chain_take;
    logic [7:0]       idle_byte, chain_byte;
    logic             unused_c_data;

    assign unused_c_data = ^c_data[7:2];

    assign c_ready   = !rst_n && (state_q == StIdle);
    assign cfg_we    = c_valid && c_ready;
    assign bit_done  = (baud_q == BaudLast);
    assign last_stop = bit_done &&
                       (((state_q == StStop1) && !frm_stop_q) || (state_q == StStop2));
    assign busy      = (state_q != StIdle);
    assign tx        = tx_q;

`ifdef UART_TX_FIFO_EN
    logic       fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [7:0] fifo_rdata;

    assign d_ready    = !rst_n && !fifo_full;
    // An empty FIFO is bypassed in IDLE so a lone byte starts on the next cycle.
    assign idle_take  = !fifo_empty || (d_valid && d_ready);
    assign idle_byte  = fifo_empty ? d_data : fifo_rdata;
    assign chain_take = !fifo_empty;
    assign chain_byte = fifo_rdata;
    assign fifo_pop   = !rst_n && !fifo_empty && ((state_q == StIdle) || last_stop);
    assign fifo_push  = d_valid && d_ready && !((state_q == StIdle) && fifo_empty);

    uart_tx_fifo #(
        .Depth (4),
        .Width (8)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (d_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );
`else
    assign d_ready    = !rst_n && (state_q == StIdle);
    assign idle_take  = d_valid && d_ready;
    assign idle_byte  = d_data;
    assign chain_take = 1'b0;
    assign chain_byte = 8'h00;
`endif

    // Config registers; a write in the accepting cycle is visible to the new frame.
    always_comb begin
        cfg_par_d  = cfg_par_q;
        cfg_stop_d = cfg_stop_q;
        if (cfg_we) begin
            if (c_addr == UART_ADDR_PARITY) cfg_par_d  = decode_parity(c_data[1:0]);
            if (c_addr == UART_ADDR_STOP)   cfg_stop_d = c_data[0];
        end
    end

    // Frame sequencing: bit timing, state transitions and per-frame snapshot.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        data_d     = data_q;
        frm_par_d  = frm_par_q;
        frm_stop_d = frm_stop_q;

        if (state_q != StIdle) begin
            baud_d = bit_done ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (idle_take) begin
                    state_d    = StStart;
                    data_d     = idle_byte;
                    frm_par_d  = cfg_par_d;
                    frm_stop_d = cfg_stop_d;
                    baud_d     = '0;
                    bit_d      = '0;
                end
            end
            StStart: begin
                if (bit_done) state_d = StData;
            end
            StData: begin
                if (bit_done) begin
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = (frm_par_q != ParNone) ? StParity : StStop1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (bit_done) state_d = StStop1;
            end
            StStop1, StStop2: begin
                if (bit_done) begin
                    if ((state_q == StStop1) && frm_stop_q) begin
                        state_d = StStop2;
                    end else if (chain_take) begin
                        // Next queued byte starts with no idle gap.
                        state_d    = StStart;
                        data_d     = chain_byte;
                        frm_par_d  = cfg_par_d;
                        frm_stop_d = cfg_stop_d;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level for the upcoming cycle, registered so tx is glitch-free.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_d[bit_d];
            StParity: tx_d = parity_bit(data_d, frm_par_d);
            default:  tx_d = 1'b1;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            cfg_par_q  <= ParNone;
            cfg_stop_q <= 1'b0;
            frm_par_q  <= ParNone;
            frm_stop_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            cfg_par_q  <= cfg_par_d;
            cfg_stop_q <= cfg_stop_d;
            frm_par_q  <= frm_par_d;
            frm_stop_q <= frm_stop_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, random frames, corner sequences.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 16;

    typedef bit bitq_t[$];

    typedef struct {
        logic [1:0] par;
        logic       stop;
        logic [7:0] data;
        bit         same;
        int         exp_len;
        int         exp_par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       d_valid = 1'b0;
    logic [7:0] d_data = 8'h00;
    logic       c_valid = 1'b0;
    logic [3:0] c_addr = 4'h0;
    logic [7:0] c_data = 8'h00;
    logic       d_ready, c_ready, tx, busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference config state.
    int m_par  = 0;
    bit m_stop = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_valid (d_valid),
        .d_data  (d_data),
        .d_ready (d_ready),
        .c_valid (c_valid),
        .c_addr  (c_addr),
        .c_data  (c_data),
        .c_ready (c_ready),
        .tx      (tx),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_write(input logic [3:0] a, input logic [7:0] d);
        if (a == 4'h5) m_par = (d[1:0] == 2'b01) ? 1 : (d[1:0] == 2'b10) ? 2 : 0;
        if (a == 4'h6) m_stop = d[0];
    endfunction

    // Bit-level frame from the line format: start, data LSB first, parity, stops.
    function automatic bitq_t frame_bits(input logic [7:0] d, input int par, input bit stop2);
        bitq_t q;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (par != 0) q.push_back((($countones(d) % 2) == 1) ^ (par == 2));
        q.push_back(1'b1);
        if (stop2) q.push_back(1'b1);
        return q;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (d_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) check({tag, " ready timeout"}, 0, 1);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        c_valid = 1'b1;
        c_addr  = a;
        c_data  = d;
        check("cfg c_ready", c_ready, 1);
        model_write(a, d);
        tick();
        c_valid = 1'b0;
    endtask

    // Send one byte and compare the whole busy window against the model.
    task automatic run_frame(input string tag, input logic [7:0] d, input bit same,
                             input logic [3:0] sa, input logic [7:0] sd,
                             input int exp_len, input int exp_par);
        bitq_t exp;
        int    cycles, bad, rdy_busy, len;
        logic  par_seen;
        wait_ready(tag);
        d_valid = 1'b1;
        d_data  = d;
        if (same) begin
            c_valid = 1'b1;
            c_addr  = sa;
            c_data  = sd;
            check({tag, " c_ready"}, c_ready, 1);
            model_write(sa, sd);
        end
        check({tag, " d_ready"}, d_ready, 1);
        exp = frame_bits(d, m_par, m_stop);
        len = (exp_len < 0) ? exp.size() * CPB : exp_len;
        tick();
        d_valid  = 1'b0;
        c_valid  = 1'b0;
        cycles   = 0;
        bad      = 0;
        rdy_busy = 0;
        par_seen = 1'bx;
        while (busy === 1'b1 && cycles < 1000) begin
            if (cycles < exp.size() * CPB) begin
                if (tx !== exp[cycles / CPB]) bad++;
            end else begin
                bad++;
            end
            if (cycles == 9 * CPB + CPB / 2) par_seen = tx;
            if (d_ready === 1'b1) rdy_busy++;
            cycles++;
            tick();
        end
        check({tag, " len"}, cycles, len);
        check({tag, " wave"}, bad, 0);
        check({tag, " tx idle"}, tx, 1);
        if (exp_par >= 0) check({tag, " parity"}, par_seen, exp_par);
`ifndef UART_TX_FIFO_EN
        check({tag, " d_ready busy"}, rdy_busy, 0);
`endif
    endtask

    initial begin
        vec_t vecs[8];
        int   cyc, k;

        vecs[0] = '{2'b00, 1'b0, 8'hA7, 1'b0, 160, -1};
        vecs[1] = '{2'b01, 1'b0, 8'hA7, 1'b0, 176,  1};
        vecs[2] = '{2'b10, 1'b0, 8'hA7, 1'b0, 176,  0};
        vecs[3] = '{2'b01, 1'b1, 8'h00, 1'b0, 192,  0};
        vecs[4] = '{2'b11, 1'b0, 8'h55, 1'b0, 160, -1};
        vecs[5] = '{2'b10, 1'b1, 8'hFF, 1'b1, 192,  1};
        vecs[6] = '{2'b00, 1'b1, 8'h3C, 1'b0, 176, -1};
        vecs[7] = '{2'b01, 1'b0, 8'h80, 1'b1, 176,  1};

        // Reset state.
        rst_n = 1'b1;
        repeat (3) tick();
        check("rst tx", tx, 1);
        check("rst busy", busy, 0);
        check("rst d_ready", d_ready, 0);
        check("rst c_ready", c_ready, 0);
        rst_n = 1'b0;
        #1;
        check("rel d_ready", d_ready, 1);
        check("rel c_ready", c_ready, 1);

        // Table vectors; "same" puts the parity write in the accepting cycle.
        for (int i = 0; i < 8; i++) begin
            wait_ready("vec");
            cfg_write(4'h6, {7'd0, vecs[i].stop});
            if (!vecs[i].same) begin
                cfg_write(4'h5, {6'd0, vecs[i].par});
                run_frame($sformatf("vec%0d", i), vecs[i].data, 1'b0, 4'h0, 8'h00,
                          vecs[i].exp_len, vecs[i].exp_par);
            end else begin
                run_frame($sformatf("vec%0d", i), vecs[i].data, 1'b1, 4'h5,
                          {6'd0, vecs[i].par}, vecs[i].exp_len, vecs[i].exp_par);
            end
        end

        // Random frames with random config traffic, including ignored addresses.
        for (int i = 0; i < 10; i++) begin
            logic [3:0] a;
            logic [7:0] d;
            bit         same;
            a    = ($urandom_range(0, 2) == 0) ? 4'(3 + $urandom_range(0, 1) * 7)
                 : ($urandom_range(0, 1) ? 4'h5 : 4'h6);
            d    = 8'($urandom);
            same = 1'($urandom);
            wait_ready("rnd");
            cfg_write(a, 8'($urandom));
            run_frame($sformatf("rnd%0d", i), d, same, same ? 4'h5 : 4'h0, 8'($urandom),
                      -1, -1);
        end

        // Config write mid-frame is refused and changes nothing.
        wait_ready("mid");
        cfg_write(4'h5, 8'h00);
        cfg_write(4'h6, 8'h00);
        d_valid = 1'b1;
        d_data  = 8'hA7;
        tick();
        d_valid = 1'b0;
        cyc = 1;
        repeat (50) begin
            tick();
            cyc++;
        end
        c_valid = 1'b1;
        c_addr  = 4'h5;
        c_data  = 8'h02;
        check("mid c_ready", c_ready, 0);
        tick();
        cyc++;
        c_valid = 1'b0;
        while (busy === 1'b1 && cyc < 1000) begin
            tick();
            cyc++;
        end
        check("mid len", cyc - 1, 160);
        run_frame("mid next", 8'hA7, 1'b0, 4'h0, 8'h00, 160, -1);

        // Reset during bit 4 aborts the frame and clears config.
        wait_ready("rst");
        cfg_write(4'h5, 8'h01);
        cfg_write(4'h6, 8'h01);
        d_valid = 1'b1;
        d_data  = 8'h5A;
        tick();
        d_valid = 1'b0;
        repeat (4 * CPB + 3) tick();
        rst_n = 1'b1;
        tick();
        check("abort tx", tx, 1);
        check("abort busy", busy, 0);
        check("abort d_ready", d_ready, 0);
        check("abort c_ready", c_ready, 0);
        rst_n = 1'b0;
        #1;
        check("abort rel d_ready", d_ready, 1);
        m_par  = 0;
        m_stop = 1'b0;
        run_frame("post rst", 8'hA7, 1'b0, 4'h0, 8'h00, 160, -1);

`ifdef UART_TX_FIFO_EN
        // Streamed bytes go out back-to-back and in order.
        begin
            bitq_t exp, rec;
            int    idx, drop_idx, bad;
            bit    started;
            for (int b = 1; b <= 6; b++) begin
                bitq_t f;
                f = frame_bits(8'(b), 0, 1'b0);
                foreach (f[j]) for (int r = 0; r < CPB; r++) exp.push_back(f[j]);
            end
            idx      = 0;
            drop_idx = -1;
            started  = 1'b0;
            cyc      = 0;
            while (cyc < 2000) begin
                if (started && busy !== 1'b1) break;
                if (busy === 1'b1) begin
                    started = 1'b1;
                    rec.push_back(tx);
                end
                if (idx < 6) begin
                    d_valid = 1'b1;
                    d_data  = 8'(idx + 1);
                    if (d_ready === 1'b1) idx++;
                    else if (drop_idx < 0) drop_idx = idx;
                end else begin
                    d_valid = 1'b0;
                end
                tick();
                cyc++;
            end
            d_valid = 1'b0;
            bad = 0;
            for (int j = 0; j < rec.size() && j < exp.size(); j++) if (rec[j] != exp[j]) bad++;
            check("fifo drop idx", drop_idx, 5);
            check("fifo accepted", idx, 6);
            check("fifo len", rec.size(), 6 * 10 * CPB);
            check("fifo wave", bad, 0);
        end
`else
        // Continuous demand: one idle cycle separates consecutive frames.
        wait_ready("gap");
        d_valid = 1'b1;
        d_data  = 8'h11;
        tick();
        d_data = 8'h22;
        k = 1;
        while (d_ready !== 1'b1 && k < 1000) begin
            tick();
            k++;
        end
        check("gap cycles", k, 10 * CPB + 1);
        check("gap tx", tx, 1);
        check("gap busy", busy, 0);
        tick();
        d_valid = 1'b0;
        check("gap start", tx, 0);
        k = 0;
        while (busy === 1'b1 && k < 1000) begin
            tick();
            k++;
        end
        check("gap len2", k, 10 * CPB);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
